// File: rtl/pci_target_ctrl.sv
// pci_target_ctrl: PCI memory-space target sequencer with medium DEVSEL# decode.
// Claims memory read (CBE 0110) and memory write (CBE 0111) cycles that fall
// inside a 2^DEC_BITS byte window at BASE_ADDR. All other cycles are ignored.
// All bus and data-path outputs come straight from flops.
// Optional feature macro: PCI_TGT_DISCONNECT_EN. When it is defined, the target
// issues a disconnect-with-data after MAX_BURST data phases.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | bus idle, watching for a FRAME# falling edge (address phase)
//   DECODE  | address claimed, one medium-decode cycle before DEVSEL#
//   DATA    | DEVSEL#/TRDY# asserted, a transfer on every edge with IRDY# low
//   BACKOFF | disconnect: DEVSEL#/STOP# held low until FRAME# deasserts
//   TURN    | one turnaround cycle with all target signals released
//   IGNORE  | cycle not ours, wait for FRAME# and IRDY# both high
module pci_target_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned DEC_BITS  = 12,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Frame,
    input  logic        Iready,
    input  logic [31:0] AD,
    input  logic [3:0]  CBE,
    output logic        Devsel,
    output logic        Tready,
    output logic        Stop,
    output logic [1:0]  RW,
    output logic [31:0] Addr,
    output logic        Xfer,
    output logic [7:0]  Count
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_BACKOFF = 3'd3;
    localparam logic [2:0] ST_TURN    = 3'd4;
    localparam logic [2:0] ST_IGNORE  = 3'd5;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    localparam logic [1:0] RW_IDLE  = 2'd0;
    localparam logic [1:0] RW_READ  = 2'd1;
    localparam logic [1:0] RW_WRITE = 2'd2;

    // Only the bits above the window size take part in the address compare.
    localparam logic [31:0] DEC_MASK = ~((32'd1 << DEC_BITS) - 32'd1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        frame_prev_q, frame_prev_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  count_q, count_d;
    logic        xfer_q, xfer_d;
    logic        devsel_q, devsel_d;
    logic        tready_q, tready_d;
    logic        stop_q, stop_d;
    logic [1:0]  rw_q, rw_d;

    logic addr_phase;
    logic addr_hit;
    logic cmd_ok;

    assign addr_phase = (state_q == ST_IDLE) && !Frame && frame_prev_q;
    assign addr_hit   = ((AD ^ BASE_ADDR) & DEC_MASK) == 32'd0;
    assign cmd_ok     = (CBE == CMD_MEM_RD) || (CBE == CMD_MEM_WR);

`ifdef PCI_TGT_DISCONNECT_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
`else
    logic [7:0] unused_burst;
    assign unused_burst = 8'(MAX_BURST);
`endif

    // Next-state, address/count datapath and registered output values.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        count_d      = count_q;
        xfer_d       = 1'b0;
        frame_prev_d = Frame;

        case (state_q)
            ST_IDLE: begin
                if (addr_phase) begin
                    addr_d  = AD;
                    cmd_d   = CBE;
                    count_d = 8'd0;
                    state_d = (addr_hit && cmd_ok) ? ST_DECODE : ST_IGNORE;
                end
            end
            ST_DECODE: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!Iready) begin
                    addr_d  = addr_q + 32'd4;
                    count_d = count_q + 8'd1;
                    xfer_d  = 1'b1;
                    if (Frame) begin
                        state_d = ST_TURN;
                    end
`ifdef PCI_TGT_DISCONNECT_EN
                    else if (!stop_q) begin
                        state_d = ST_BACKOFF;
                    end
`endif
                end
            end
            ST_BACKOFF: begin
                if (Frame) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            ST_IGNORE: begin
                if (Frame && Iready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the state being entered so they line up with it.
        devsel_d = !((state_d == ST_DATA) || (state_d == ST_BACKOFF));
        tready_d = !(state_d == ST_DATA);
        if (state_d == ST_DATA) begin
            rw_d = (cmd_d == CMD_MEM_WR) ? RW_WRITE : RW_READ;
        end else begin
            rw_d = RW_IDLE;
        end
`ifdef PCI_TGT_DISCONNECT_EN
        stop_d = !(((state_d == ST_DATA) && (count_d == BURST_LAST)) ||
                   (state_d == ST_BACKOFF));
`else
        stop_d = 1'b1;
`endif
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= 4'd0;
            frame_prev_q <= 1'b0;
            addr_q       <= 32'd0;
            count_q      <= 8'd0;
            xfer_q       <= 1'b0;
            devsel_q     <= 1'b1;
            tready_q     <= 1'b1;
            stop_q       <= 1'b1;
            rw_q         <= RW_IDLE;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            frame_prev_q <= frame_prev_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            xfer_q       <= xfer_d;
            devsel_q     <= devsel_d;
            tready_q     <= tready_d;
            stop_q       <= stop_d;
            rw_q         <= rw_d;
        end
    end

    assign Devsel = devsel_q;
    assign Tready = tready_q;
    assign Stop   = stop_q;
    assign RW     = rw_q;
    assign Addr   = addr_q;
    assign Xfer   = xfer_q;
    assign Count  = count_q;

endmodule

// File: doc/pci_target_ctrl.md
PCI_TARGET_CTRL -- requirements
Module: pci_target_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000: base address of the target memory window.
REQ-002 Parameter DEC_BITS, default 12: window size is 2^DEC_BITS bytes; AD[31:DEC_BITS] is compared with BASE_ADDR[31:DEC_BITS].
REQ-003 Parameter MAX_BURST, default 8, legal range 1..255: maximum data phases per transaction when disconnect is compiled in.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Frame  input  1  PCI FRAME#, active-low.
REQ-007 Iready  input  1  PCI IRDY#, active-low.
REQ-008 AD  input  32  address/data bus; sampled only in the address phase.
REQ-009 CBE  input  4  command; sampled only in the address phase.
REQ-010 Devsel  output  1  PCI DEVSEL#, active-low.
REQ-011 Tready  output  1  PCI TRDY#, active-low.
REQ-012 Stop  output  1  PCI STOP#, active-low.
REQ-013 RW  output  2  data-path command: 0 idle, 1 read, 2 write; 3 is never driven.
REQ-014 Addr  output  32  current data-phase byte address.
REQ-015 Xfer  output  1  high for exactly the cycle after each completed data transfer.
REQ-016 Count  output  8  number of completed transfers in the current transaction.

Function
REQ-017 States SHALL be IDLE, DECODE, DATA, BACKOFF, TURN and IGNORE; all outputs SHALL be registered.
REQ-018 IDLE: an address phase is a rising edge with Frame==0 and Frame==1 on the previous edge; AD SHALL be latched into Addr, CBE into the internal command register, and Count SHALL be cleared.
REQ-019 Address phase with CBE==4'b0110 (memory read) or 4'b0111 (memory write) and an address match SHALL go to DECODE; any other address phase SHALL go to IGNORE.
REQ-020 DECODE SHALL last exactly one cycle with Devsel, Tready and Stop at 1, then go to DATA (medium decode: Devsel low on the second edge after the address phase).
REQ-021 In DATA, Devsel and Tready SHALL be 0, and RW SHALL be 1 for read or 2 for write; RW SHALL be 0 in every other state.
REQ-022 A transfer is a rising edge in DATA with Iready==0; on it Addr SHALL increase by 4 (mod 2^32), Count SHALL increment (wrapping at 255), and Xfer SHALL pulse.
REQ-023 In DATA, Iready==1 is a wait state: Addr, Count and the state SHALL hold.
REQ-024 A transfer with Frame==1 is the last data phase and SHALL go to TURN; a transfer with Frame==0 SHALL stay in DATA.
REQ-025 TURN SHALL last one cycle with Devsel, Tready and Stop at 1, then go to IDLE.
REQ-026 IGNORE SHALL keep all outputs deasserted until an edge samples Frame==1 and Iready==1, then go to IDLE.
REQ-027 BACKOFF SHALL drive Devsel=0, Stop=0 and Tready=1 until an edge samples Frame==1, then go to TURN.

Reset
REQ-028 Reset==0 SHALL immediately force IDLE, Devsel=1, Tready=1, Stop=1, RW=0, Addr=0, Xfer=0 and Count=0, regardless of the clock, including mid-transaction.
REQ-029 After Reset is released, the first address phase SHALL require Frame==1 to have been sampled on at least one prior edge.

Configuration
REQ-030 Macro PCI_TGT_DISCONNECT_EN defined: in DATA, Stop SHALL be 0 whenever Count==MAX_BURST-1 (disconnect with data).
REQ-031 With the macro defined, a transfer made while Stop==0 and Frame==0 SHALL go to BACKOFF; if Frame==1 it SHALL go to TURN.
REQ-032 Macro not defined: Stop SHALL be constantly 1, BACKOFF SHALL be unreachable, and bursts SHALL be unlimited.

Verification
REQ-033 Memory write, Addr 0x1000_0040, single phase (Frame rises with Iready==0) -> Devsel low two edges after the address phase, RW=2 for one DATA cycle, Xfer once, Count=1, Addr=0x1000_0044, TURN, then IDLE.
REQ-034 Memory-read burst of 3 with Iready held high for 2 cycles before the second transfer -> RW=1 throughout DATA, Addr and Count frozen during the wait, final Count=3, Addr=base+12.
REQ-035 Address 0x2000_0000, or CBE=4'b0010 (I/O read) -> IGNORE; Devsel never asserted; return to IDLE once Frame=1 and Iready=1.
REQ-036 With PCI_TGT_DISCONNECT_EN and MAX_BURST=4, a 10-phase write -> Stop=0 on the 4th phase, Count=4, BACKOFF until Frame=1, then TURN and IDLE; without the macro all 10 transfers complete with Stop=1.
REQ-037 Reset pulsed low mid-burst after 2 transfers -> outputs take their reset values asynchronously; the next valid address phase restarts with Count=0.
